// File: rtl/bz_pkg.sv
// Shared constants and types for the buzzer tone path.
// Note periods are clk cycles per PWM period at 50 MHz.
package bz_pkg;

  localparam int BZ_PERIOD_W = 20;

  localparam logic [BZ_PERIOD_W-1:0] BZ_REST = 20'd0;
  localparam logic [BZ_PERIOD_W-1:0] BZ_DO   = 20'd191131;
  localparam logic [BZ_PERIOD_W-1:0] BZ_RE   = 20'd170242;
  localparam logic [BZ_PERIOD_W-1:0] BZ_MI   = 20'd151699;
  localparam logic [BZ_PERIOD_W-1:0] BZ_FA   = 20'd143184;
  localparam logic [BZ_PERIOD_W-1:0] BZ_SOL  = 20'd127551;
  localparam logic [BZ_PERIOD_W-1:0] BZ_LA   = 20'd113636;
  localparam logic [BZ_PERIOD_W-1:0] BZ_XI   = 20'd101235;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } bz_state_e;

  // High time of the square wave for a given volume.
  // Volume 3 is 50% duty; each step down halves it.
  function automatic logic [BZ_PERIOD_W-1:0] bz_high_time(
    input logic [BZ_PERIOD_W-1:0] p,
    input logic [1:0]             vol
  );
    logic [BZ_PERIOD_W-1:0] h;
    unique case (vol)
      2'd3:    h = p >> 1;
      2'd2:    h = p >> 2;
      2'd1:    h = p >> 3;
      default: h = p >> 4;
    endcase
    return h;
  endfunction

endpackage

// File: rtl/bz_tone_player_if.sv
// Note request handshake between sequencer and tone player.
// Signals: note_period, note_beats, note_valid, note_ready (+volume with BZ_VOLUME_EN).
interface bz_tone_player_if
  import bz_pkg::*;
#(
  parameter int BEAT_W = 4
) ();

  logic [BZ_PERIOD_W-1:0] note_period;
  logic [BEAT_W-1:0]      note_beats;
  logic                   note_valid;
  logic                   note_ready;
`ifdef BZ_VOLUME_EN
  logic [1:0]             volume;

  modport master (
    output note_period,
    output note_beats,
    output note_valid,
    output volume,
    input  note_ready
  );

  modport slave (
    input  note_period,
    input  note_beats,
    input  note_valid,
    input  volume,
    output note_ready
  );
`else
  modport master (
    output note_period,
    output note_beats,
    output note_valid,
    input  note_ready
  );

  modport slave (
    input  note_period,
    input  note_beats,
    input  note_valid,
    output note_ready
  );
`endif

endinterface

// File: rtl/bz_pwm_core.sv
// Square-wave generator: period counter plus high-time comparator.
// Ports: clk, rst_n, enable, period, high_time in; registered buzzer out.
module bz_pwm_core
  import bz_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [BZ_PERIOD_W-1:0] period,
  input  logic [BZ_PERIOD_W-1:0] high_time,
  output logic                   buzzer
);

  localparam logic [BZ_PERIOD_W-1:0] P_ONE = 1;

  logic [BZ_PERIOD_W-1:0] pc_q;
  logic                   wrap;

  // pc_q is the phase of the cycle the next buzzer value
  // belongs to, so the first enabled edge drives phase 0.
  assign wrap = (pc_q >= period - P_ONE);

  always_ff @(posedge clk) begin
    if (!rst_n || !enable) begin
      pc_q   <= '0;
      buzzer <= 1'b0;
    end else begin
      buzzer <= (pc_q < high_time);
      pc_q   <= wrap ? '0 : pc_q + P_ONE;
    end
  end

endmodule

// File: rtl/bz_tone_player.sv
// Tone player: plays a note for N beats, then a silent gap, then pulses note_done.
// Ports: clk, rst_n, nif (slave), abort in; buzzer, busy, note_done out. Macro BZ_VOLUME_EN adds volume.
module bz_tone_player
  import bz_pkg::*;
#(
  parameter int BEAT_CYCLES = 12_500_000,
  parameter int GAP_CYCLES  = 500_000,
  parameter int BEAT_W      = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  bz_tone_player_if.slave nif,
  input  logic            abort,
  output logic            buzzer,
  output logic            busy,
  output logic            note_done
);

  localparam int BC_W =
    (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam int GC_W =
    (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [BC_W-1:0] BC_LAST =
    BC_W'(BEAT_CYCLES - 1);
  localparam logic [GC_W-1:0] GC_LAST =
    GC_W'(GAP_CYCLES - 1);
  localparam logic [BEAT_W-1:0] B_ONE = 1;

  bz_state_e state_q;
  bz_state_e state_d;

  logic [BZ_PERIOD_W-1:0] period_q;
  logic [BEAT_W-1:0]      beats_q;
  logic [BEAT_W-1:0]      beat_q;
  logic [BEAT_W-1:0]      beats_in;
  logic [BC_W-1:0]        bcyc_q;
  logic [GC_W-1:0]        gcnt_q;

  logic ready_q;
  logic done_d;
  logic hs;
  logic beat_last;
  logic play_last;
  logic gap_last;

  logic                   pwm_en;
  logic [BZ_PERIOD_W-1:0] pwm_period;
  logic [BZ_PERIOD_W-1:0] pwm_high;
  logic [1:0]             vol_sel;

  assign beats_in = nif.note_beats;

  assign hs = nif.note_valid
            & (state_q == ST_IDLE)
            & ~abort;

  assign beat_last = (bcyc_q == BC_LAST);
  assign play_last = beat_last
                   && (beat_q == beats_q - B_ONE);
  assign gap_last  = (gcnt_q == GC_LAST);

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (nif.note_valid) state_d = ST_PLAY;
        end
        ST_PLAY: begin
          if (play_last) state_d = ST_GAP;
        end
        ST_GAP: begin
          if (gap_last) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || abort) begin
      bcyc_q <= '0;
      beat_q <= '0;
      gcnt_q <= '0;
      if (!rst_n) begin
        period_q <= '0;
        beats_q  <= '0;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (hs) begin
            period_q <= nif.note_period;
            beats_q  <= (beats_in == '0) ? B_ONE
                                         : beats_in;
            bcyc_q   <= '0;
            beat_q   <= '0;
            gcnt_q   <= '0;
          end
        end
        ST_PLAY: begin
          if (play_last) begin
            bcyc_q <= '0;
            beat_q <= '0;
          end else if (beat_last) begin
            bcyc_q <= '0;
            beat_q <= beat_q + B_ONE;
          end else begin
            bcyc_q <= bcyc_q + 1'b1;
          end
        end
        ST_GAP: begin
          gcnt_q <= gap_last ? '0 : gcnt_q + 1'b1;
        end
        default: begin
          bcyc_q <= '0;
          beat_q <= '0;
          gcnt_q <= '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they
  // line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      ready_q   <= 1'b1;
      note_done <= 1'b0;
    end else begin
      busy      <= (state_d != ST_IDLE);
      ready_q   <= (state_d == ST_IDLE);
      note_done <= done_d;
    end
  end

  assign nif.note_ready = ready_q;

`ifdef BZ_VOLUME_EN
  logic [1:0] vol_q;

  always_ff @(posedge clk) begin
    if (!rst_n)  vol_q <= 2'd0;
    else if (hs) vol_q <= nif.volume;
  end

  assign vol_sel = hs ? nif.volume : vol_q;
`else
  assign vol_sel = 2'd3;
`endif

  // On the handshake edge the latches are still loading,
  // so the core sees the incoming note directly.
  assign pwm_en     = (state_d == ST_PLAY);
  assign pwm_period = hs ? nif.note_period : period_q;
  assign pwm_high   = bz_high_time(pwm_period, vol_sel);

  bz_pwm_core u_pwm (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (pwm_en),
    .period    (pwm_period),
    .high_time (pwm_high),
    .buzzer    (buzzer)
  );

endmodule

// File: tb/tb_bz_tone_player.sv
// Self-checking bench for bz_tone_player against a cycle-index model.
// Optional BZ_VOLUME_EN build also exercises the volume input.
module tb_bz_tone_player;
  import bz_pkg::*;

  localparam int BC = 100;
  localparam int GC = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic abort = 1'b0;
  logic buzzer;
  logic busy;
  logic note_done;

  int checks = 0;
  int failures = 0;

  bz_tone_player_if #(.BEAT_W(4)) nif ();

  bz_tone_player #(
    .BEAT_CYCLES (BC),
    .GAP_CYCLES  (GC),
    .BEAT_W      (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .nif       (nif),
    .abort     (abort),
    .buzzer    (buzzer),
    .busy      (busy),
    .note_done (note_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Buzzer level in PLAY cycle k (1-based): high for the
  // first (P >> (4-vol)) cycles of every P-cycle period.
  function automatic logic model_buz(int p, int vol, int k);
    int hi;
    if (p < 2) return 1'b0;
    hi = p >> (4 - vol);
    return (((k - 1) % p) < hi);
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_buzzer"}, buzzer, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ready"}, nif.note_ready, 1);
    chk({tag, "_done"}, note_done, 0);
  endtask

  task automatic idle(input int n);
    nif.note_valid = 1'b0;
    repeat (n) begin
      @(negedge clk);
      chk_idle("idle");
    end
  endtask

  // Present a note in the current cycle and follow it to the
  // note_done cycle, or stop kill_at cycles in via abort/reset.
  task automatic run_note(input int p, input int b,
                          input int vol, input int kill_at,
                          input bit kill_rst, input bit hold,
                          input int hp, input int hb);
    int beff;
    int play_n;
    int total;
    string t;
    beff = (b == 0) ? 1 : b;
    play_n = beff * BC;
    total = play_n + GC;
    nif.note_period = 20'(p);
    nif.note_beats = 4'(b);
`ifdef BZ_VOLUME_EN
    nif.volume = 2'(vol);
`endif
    nif.note_valid = 1'b1;
    for (int k = 1; k <= total + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (hold) begin
          nif.note_period = 20'(hp);
          nif.note_beats = 4'(hb);
        end else begin
          nif.note_valid = 1'b0;
        end
      end
      t = $sformatf("p%0d_b%0d_v%0d_k%0d", p, b, vol, k);
      chk({t, "_buzzer"}, buzzer,
          (k <= play_n) ? model_buz(p, vol, k) : 1'b0);
      chk({t, "_busy"}, busy, (k <= total));
      chk({t, "_ready"}, nif.note_ready, (k > total));
      chk({t, "_done"}, note_done, (k > total));
      if (k == kill_at) begin
        if (kill_rst) rst_n = 1'b0;
        else          abort = 1'b1;
        @(negedge clk);
        chk_idle(kill_rst ? "after_rst" : "after_abort");
        rst_n = 1'b1;
        abort = 1'b0;
        return;
      end
    end
  endtask

  initial begin
    int p;
    int b;
    int v;
    int g;
    nif.note_period = '0;
    nif.note_beats = '0;
    nif.note_valid = 1'b0;
`ifdef BZ_VOLUME_EN
    nif.volume = 2'd3;
`endif

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst_n = 1'b1;
    idle(2);

    // basic, odd period, rest, zero beats
    run_note(20, 2, 3, 0, 0, 0, 0, 0);
    idle(3);
    run_note(7, 1, 3, 0, 0, 0, 0, 0);
    idle(1);
    run_note(0, 1, 3, 0, 0, 0, 0, 0);
    idle(1);
    run_note(13, 0, 3, 0, 0, 0, 0, 0);
    idle(1);

    // valid held with the next note: ignored until done cycle
    run_note(20, 1, 3, 0, 0, 1, 9, 1);
    run_note(9, 1, 3, 0, 0, 0, 0, 0);
    idle(2);

    // abort in PLAY cycle 50, no note_done afterwards
    run_note(20, 2, 3, 50, 0, 0, 0, 0);
    idle(15);

    // abort wins over a handshake in IDLE
    nif.note_period = 20'd20;
    nif.note_beats = 4'd1;
    nif.note_valid = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    chk_idle("abort_hs");
    abort = 1'b0;
    idle(3);

    // reset in the middle of GAP
    run_note(10, 1, 3, 105, 1, 0, 0, 0);
    idle(3);

`ifdef BZ_VOLUME_EN
    run_note(32, 1, 0, 0, 0, 0, 0, 0);
    idle(1);
    run_note(32, 1, 3, 0, 0, 0, 0, 0);
    idle(1);
    run_note(40, 1, 1, 0, 0, 0, 0, 0);
    idle(1);
`endif

    // random notes, some back-to-back
    for (int i = 0; i < 8; i++) begin
      p = int'($urandom_range(0, 40));
      b = int'($urandom_range(0, 3));
`ifdef BZ_VOLUME_EN
      v = int'($urandom_range(0, 3));
`else
      v = 3;
`endif
      g = int'($urandom_range(0, 2));
      run_note(p, b, v, 0, 0, 0, 0, 0);
      if (g > 0) idle(g);
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
